// File: rtl/soc_bus_timer.sv
// soc_bus_timer: memory-mapped 64-bit timer with prescaler, 64-bit compare, sticky pending flag and level interrupt.
// Latency: a request is accepted in IDLE and its response is presented the following cycle; one request outstanding.
// Backpressure: the response is held stable while rsp_ready_i is low and req_ready_o stays low until the handshake.
module soc_bus_timer #(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [7:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        irq_o
);
    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PRESC    = 8'h04;
    localparam logic [7:0] ADDR_MTIME_LO = 8'h08;
    localparam logic [7:0] ADDR_MTIME_HI = 8'h0C;
    localparam logic [7:0] ADDR_CMP_LO   = 8'h10;
    localparam logic [7:0] ADDR_CMP_HI   = 8'h14;
    localparam logic [7:0] ADDR_STATUS   = 8'h18;

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;

    logic               en, irq_en, pend, cmp_ge;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [63:0]        mtime, cmp;
    logic [31:0]        shadow, cur_val, rd_val, wval;
    logic               acc, addr_err, wr, rd, tick;
    logic               wr_ctrl, wr_presc, wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, pend_clr;

    // Request decode: misaligned or out-of-map addresses error out and touch nothing.
    assign acc      = req_valid_i && (state == IDLE);
    assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i > ADDR_STATUS);
    assign wr       = acc && req_we_i && !addr_err && (req_be_i != 4'b0000);
    assign rd       = acc && !req_we_i && !addr_err;

    assign wr_ctrl   = wr && (req_addr_i == ADDR_CTRL);
    assign wr_presc  = wr && (req_addr_i == ADDR_PRESC);
    assign wr_mt_lo  = wr && (req_addr_i == ADDR_MTIME_LO);
    assign wr_mt_hi  = wr && (req_addr_i == ADDR_MTIME_HI);
    assign wr_cmp_lo = wr && (req_addr_i == ADDR_CMP_LO);
    assign wr_cmp_hi = wr && (req_addr_i == ADDR_CMP_HI);
    assign pend_clr  = wr && (req_addr_i == ADDR_STATUS) && req_be_i[0] && req_wdata_i[0];

    // Current architectural value of the addressed register (live mtime high word, not the shadow).
    always_comb begin
        cur_val = 32'h0;
        case (req_addr_i)
            ADDR_CTRL:     cur_val = {30'h0, irq_en, en};
            ADDR_PRESC:    cur_val[PRESC_W-1:0] = presc;
            ADDR_MTIME_LO: cur_val = mtime[31:0];
            ADDR_MTIME_HI: cur_val = mtime[63:32];
            ADDR_CMP_LO:   cur_val = cmp[31:0];
            ADDR_CMP_HI:   cur_val = cmp[63:32];
            ADDR_STATUS:   cur_val = {31'h0, pend};
            default:       cur_val = 32'h0;
        endcase
    end

    // Byte-lane merge of write data into the current value; reads of MTIME_HI return the snapshot.
    always_comb begin
        wval = cur_val;
        for (int i = 0; i < 4; i++) begin
            if (req_be_i[i]) wval[8*i +: 8] = req_wdata_i[8*i +: 8];
        end
        rd_val = (req_addr_i == ADDR_MTIME_HI) ? shadow : cur_val;
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: accept in IDLE, hold the response until the consumer takes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid_i) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    // Response payload captured at acceptance; writes and errors return zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else if (acc) begin
            rsp_rdata_o <= (req_we_i || addr_err) ? 32'h0 : rd_val;
            rsp_err_o   <= addr_err;
        end
    end

    // Control and compare registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            presc  <= '0;
            cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_ctrl) begin
                en     <= wval[0];
                irq_en <= wval[1];
            end
            if (wr_presc)  presc       <= wval[PRESC_W-1:0];
            if (wr_cmp_lo) cmp[31:0]   <= wval;
            if (wr_cmp_hi) cmp[63:32]  <= wval;
        end
    end

    assign tick = en && (pcnt == presc);

    // Prescaler and mtime; a bus write to either mtime word suppresses that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            mtime <= 64'h0;
        end else begin
            if (wr_ctrl || wr_presc) pcnt <= '0;
            else if (en)             pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
            if (wr_mt_lo || wr_mt_hi) begin
                if (wr_mt_lo) mtime[31:0]  <= wval;
                if (wr_mt_hi) mtime[63:32] <= wval;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // High-word snapshot taken whenever MTIME_LO is read, so LO then HI reads are coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 shadow <= 32'h0;
        else if (rd && req_addr_i == ADDR_MTIME_LO) shadow <= mtime[63:32];
    end

    // Registered compare feeds a sticky pending flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_ge <= 1'b0;
            pend   <= 1'b0;
        end else begin
            cmp_ge <= (mtime >= cmp);
            pend   <= cmp_ge || (pend && !pend_clr);
        end
    end

    assign irq_o = pend && irq_en;

endmodule

// File: tb/tb_soc_bus_timer.sv
`timescale 1ns/1ps
module tb_soc_bus_timer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, irq_o;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soc_bus_timer #(.PRESC_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .irq_o(irq_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete transfer; acc is the index of the clock edge that accepted the request.
    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int acc);
        int n;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_be_i = be; rsp_ready_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_accept addr=%h: req_ready_o=%b, required 1", addr, req_ready_o);
        end
        acc = cyc + 1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (rsp_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_response addr=%h: rsp_valid_o=%b, required 1", addr, rsp_valid_o);
        end
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 1", req_ready_o); end
        n_tests++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid_o); end
        n_tests++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata_o); end
        n_tests++; if (rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", rsp_err_o); end
        n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, required 0", irq_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int a;
        do_reset();
        bus(1'b0, 8'h02, 32'h0, 4'h0, d, e, a);
        n_tests++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL err_misaligned: err=%b rdata=%h, required 1/0", e, d); end
        bus(1'b0, 8'h1C, 32'h0, 4'h0, d, e, a);
        n_tests++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL err_range: err=%b rdata=%h, required 1/0", e, d); end
        bus(1'b1, 8'h01, 32'h3, 4'hF, d, e, a);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_write: err=%b, required 1", e); end
        bus(1'b0, 8'h00, 32'h0, 4'h0, d, e, a);
        n_tests++; if (e !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL err_no_effect: ctrl=%h err=%b, required 0/0", d, e); end
        bus(1'b1, 8'h10, 32'hAABBCCDD, 4'b0001, d, e, a);
        bus(1'b0, 8'h10, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'hFFFF_FFDD) begin n_fail++; $display("FAIL byte_enable: cmp_lo=%h, required ffffffdd", d); end
        bus(1'b1, 8'h04, 32'hFF, 4'b0000, d, e, a);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL be0_err: err=%b, required 0", e); end
        bus(1'b0, 8'h04, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL be0_noop: presc=%h, required 0", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int a;
        do_reset();
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'h10; req_be_i = 4'h0;
        req_wdata_i = 32'h0; rsp_ready_i = 1'b0;
        @(posedge clk); #1;
        // second request, a CTRL write, stays offered through the stall
        req_we_i = 1'b1; req_addr_i = 8'h00; req_wdata_i = 32'h1; req_be_i = 4'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FFFF || req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: valid=%b rdata=%h ready=%b, required 1/ffffffff/0",
                         i, rsp_valid_o, rsp_rdata_o, req_ready_o);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: valid=%b ready=%b, required 0/1", rsp_valid_o, req_ready_o);
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL second_req: valid=%b err=%b rdata=%h, required 1/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        @(posedge clk); #1;
        bus(1'b0, 8'h00, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL second_req_effect: ctrl=%h, required 1", d); end
    endtask

    task automatic test_random_regs();
        logic [7:0]  good_addr [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        logic [1:0]  m_ctrl = 2'b0;
        logic [7:0]  m_presc = 8'h0;
        logic [63:0] m_mtime = 64'h0, m_cmp = '1;
        logic [31:0] m_shadow = 32'h0, t, d, exp_d, wdat;
        logic        m_pend = 1'b0, e, we, bad;
        logic [7:0]  addr;
        logic [3:0]  be;
        int a;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                addr = 8'($urandom_range(0, 255));
                if (addr[1:0] == 2'b00 && addr <= 8'h18) addr[0] = 1'b1;
            end else begin
                addr = good_addr[$urandom_range(0, 5)];
            end
            we   = 1'($urandom_range(0, 1));
            wdat = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (addr == 8'h00) wdat[0] = 1'b0;
            bus(we, addr, wdat, be, d, e, a);
            bad   = (addr[1:0] != 2'b00) || (addr > 8'h18);
            exp_d = 32'h0;
            if (!bad && we) begin
                case (addr)
                    8'h00: begin t = merge_be({30'h0, m_ctrl}, wdat, be); m_ctrl = t[1:0]; end
                    8'h04: begin t = merge_be({24'h0, m_presc}, wdat, be); m_presc = t[7:0]; end
                    8'h08: m_mtime[31:0]  = merge_be(m_mtime[31:0], wdat, be);
                    8'h0C: m_mtime[63:32] = merge_be(m_mtime[63:32], wdat, be);
                    8'h10: m_cmp[31:0]    = merge_be(m_cmp[31:0], wdat, be);
                    8'h14: m_cmp[63:32]   = merge_be(m_cmp[63:32], wdat, be);
                    default: ;
                endcase
            end else if (!bad) begin
                case (addr)
                    8'h00: exp_d = {30'h0, m_ctrl};
                    8'h04: exp_d = {24'h0, m_presc};
                    8'h08: begin exp_d = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                    8'h0C: exp_d = m_shadow;
                    8'h10: exp_d = m_cmp[31:0];
                    8'h14: exp_d = m_cmp[63:32];
                    default: ;
                endcase
            end
            if (m_mtime >= m_cmp) m_pend = 1'b1;
            n_tests++;
            if (e !== bad || d !== exp_d) begin
                n_fail++;
                $display("FAIL random_access it=%0d we=%b addr=%h be=%h: err=%b rdata=%h, required %b/%h",
                         it, we, addr, be, e, d, bad, exp_d);
            end
        end
        repeat (4) @(negedge clk);
        bus(1'b0, 8'h18, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== {31'h0, m_pend}) begin n_fail++; $display("FAIL random_pend: status=%h, required %0d", d, m_pend); end
        @(negedge clk);
        n_tests++; if (irq_o !== (m_pend & m_ctrl[1])) begin n_fail++; $display("FAIL random_irq: irq=%b, required %b", irq_o, m_pend & m_ctrl[1]); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d, d2; logic e; int a, en_edge, r, off_edge;
        do_reset();
        bus(1'b1, 8'h04, 32'h3, 4'h1, d, e, a);
        bus(1'b1, 8'h00, 32'h1, 4'h1, d, e, en_edge);
        repeat (40) @(negedge clk);
        bus(1'b0, 8'h08, 32'h0, 4'h0, d, e, r);
        n_tests++;
        if (d !== 32'((r - 1 - en_edge) / 4)) begin
            n_fail++; $display("FAIL presc_count: mtime_lo=%0d, required %0d", d, (r - 1 - en_edge) / 4);
        end
        bus(1'b1, 8'h00, 32'h0, 4'h1, d, e, off_edge);
        bus(1'b0, 8'h08, 32'h0, 4'h0, d, e, a);
        repeat (5) @(negedge clk);
        bus(1'b0, 8'h08, 32'h0, 4'h0, d2, e, a);
        n_tests++;
        if (d !== 32'((off_edge - en_edge) / 4) || d2 !== d) begin
            n_fail++; $display("FAIL presc_freeze: reads %0d,%0d, required %0d", d, d2, (off_edge - en_edge) / 4);
        end
    endtask

    task automatic test_carry();
        logic [31:0] lo1, hi2, lo3, hi4; logic e; int a, en_edge, r1, r3;
        logic [63:0] v1, v3;
        do_reset();
        bus(1'b1, 8'h08, 32'hFFFF_FFFE, 4'hF, lo1, e, a);
        bus(1'b1, 8'h00, 32'h1, 4'h1, lo1, e, en_edge);
        bus(1'b0, 8'h08, 32'h0, 4'h0, lo1, e, r1);
        bus(1'b0, 8'h0C, 32'h0, 4'h0, hi2, e, a);
        bus(1'b0, 8'h08, 32'h0, 4'h0, lo3, e, r3);
        bus(1'b0, 8'h0C, 32'h0, 4'h0, hi4, e, a);
        v1 = 64'h0000_0000_FFFF_FFFE + 64'(r1 - 1 - en_edge);
        v3 = 64'h0000_0000_FFFF_FFFE + 64'(r3 - 1 - en_edge);
        n_tests++; if (lo1 !== v1[31:0])  begin n_fail++; $display("FAIL carry_lo1: got %h, required %h", lo1, v1[31:0]); end
        n_tests++; if (hi2 !== v1[63:32]) begin n_fail++; $display("FAIL carry_hi1: got %h, required %h", hi2, v1[63:32]); end
        n_tests++; if (lo3 !== v3[31:0])  begin n_fail++; $display("FAIL carry_lo2: got %h, required %h", lo3, v3[31:0]); end
        n_tests++; if (hi4 !== v3[63:32]) begin n_fail++; $display("FAIL carry_hi2: got %h, required %h", hi4, v3[63:32]); end
    endtask

    task automatic test_compare();
        logic [31:0] d; logic e; int a, en_edge, rise, n;
        do_reset();
        bus(1'b1, 8'h10, 32'h5, 4'hF, d, e, a);
        bus(1'b1, 8'h14, 32'h0, 4'hF, d, e, a);
        bus(1'b1, 8'h00, 32'h3, 4'h1, d, e, en_edge);
        n = 0;
        @(negedge clk);
        while (irq_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        rise = cyc;
        n_tests++;
        if (irq_o !== 1'b1 || rise - en_edge > 7) begin
            n_fail++; $display("FAIL cmp_irq_rise: irq=%b after %0d cycles, required 1 within 7", irq_o, rise - en_edge);
        end
        bus(1'b0, 8'h18, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL cmp_pend: status=%h, required 1", d); end
        bus(1'b1, 8'h18, 32'h1, 4'h1, d, e, a);
        bus(1'b0, 8'h18, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL cmp_reset_after_w1c: status=%h, required 1", d); end
        bus(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, d, e, a);
        bus(1'b1, 8'h14, 32'hFFFF_FFFF, 4'hF, d, e, a);
        bus(1'b1, 8'h18, 32'h1, 4'h1, d, e, a);
        repeat (3) @(negedge clk);
        bus(1'b0, 8'h18, 32'h0, 4'h0, d, e, a);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL cmp_w1c_clear: status=%h, required 0", d); end
        @(negedge clk);
        n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL cmp_irq_clear: irq=%b, required 0", irq_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi; logic e; int a, en_edge, r;
        logic [63:0] v;
        do_reset();
        bus(1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, lo, e, a);
        bus(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, lo, e, a);
        bus(1'b1, 8'h00, 32'h1, 4'h1, lo, e, en_edge);
        bus(1'b0, 8'h08, 32'h0, 4'h0, lo, e, r);
        bus(1'b0, 8'h0C, 32'h0, 4'h0, hi, e, a);
        v = 64'hFFFF_FFFF_FFFF_FFFF + 64'(r - 1 - en_edge);
        n_tests++;
        if (lo !== v[31:0] || hi !== v[63:32]) begin
            n_fail++; $display("FAIL wrap64: got %h_%h, required %h_%h", hi, lo, v[63:32], v[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  addrs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        logic [31:0] rstv  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] d; logic e; int a;
        do_reset();
        bus(1'b1, 8'h04, 32'h55, 4'h1, d, e, a);
        bus(1'b1, 8'h00, 32'h3, 4'h1, d, e, a);
        bus(1'b1, 8'h10, 32'h0, 4'hF, d, e, a);
        bus(1'b1, 8'h14, 32'h0, 4'hF, d, e, a);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 8'h04; req_wdata_i = 32'hAA;
        req_be_i = 4'h1; rsp_ready_i = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        n_tests++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_resp: valid=%b, required 1", rsp_valid_o); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || irq_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: valid=%b ready=%b irq=%b, required 0/1/0", rsp_valid_o, req_ready_o, irq_o);
        end
        @(negedge clk);
        rst = 1'b0; rsp_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus(1'b0, addrs[i], 32'h0, 4'h0, d, e, a);
            n_tests++;
            if (d !== rstv[i] || e !== 1'b0) begin
                n_fail++; $display("FAIL mid_regs addr=%h: rdata=%h err=%b, required %h/0", addrs[i], d, e, rstv[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 8'h0;
        req_wdata_i = 32'h0; req_be_i = 4'h0; rsp_ready_i = 1'b1;
        test_reset();
        test_errors();
        test_backpressure();
        test_random_regs();
        test_prescaler();
        test_carry();
        test_compare();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
